// File: rtl/dmem_responder.sv
// Word-addressed data memory with a valid/ready request port and a fixed-latency response pulse.
// Define DMEM_RANGE_CHECK_EN to flag accesses whose address bits above the RAM index are nonzero.
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;
    logic [31:0]        mem_q [DEPTH_WORDS];

    logic               service;
    logic [IDX_W-1:0]   idx;
    logic               rangeErr;
    logic               err;
    logic               memWrite;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The service happens on the edge entering RESP; with LATENCY=1 that is the
    // acceptance edge itself, so the request is taken from the _d side.
    always_comb begin
        service = (state_d == RESP) && (state_q != RESP);
        idx     = addr_d[2 +: IDX_W];
`ifdef DMEM_RANGE_CHECK_EN
        rangeErr = (addr_d >> (IDX_W + 2)) != 32'd0;
`else
        rangeErr = 1'b0;
`endif
        err         = (addr_d[1:0] != 2'b00) || rangeErr;
        memWrite    = service && we_d && !err;
        rsp_valid_d = service;
        rsp_err_d   = service && err;
        rsp_rdata_d = (service && !we_d && !err) ? mem_q[idx] : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // RAM has no reset; a reset edge only suppresses a pending store.
    always_ff @(posedge clk) begin
        if (reset && memWrite) begin
            mem_q[idx] <= wdata_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances at LATENCY 2, 1 and 4 sharing clock and reset.
// Expected values for the out-of-range load follow DMEM_RANGE_CHECK_EN.
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        reqValid [3];
    logic        reqReady [3];
    logic        reqWe    [3];
    logic [31:0] reqAddr  [3];
    logic [31:0] reqWdata [3];
    logic        rspValid [3];
    logic [31:0] rspRdata [3];
    logic        rspErr   [3];
    logic        busySig  [3];

    int assertCount = 0;
    int failCount   = 0;

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dutLat2 (
        .clk(clk), .reset(reset),
        .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_we(reqWe[0]),
        .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]),
        .rsp_valid(rspValid[0]), .rsp_rdata(rspRdata[0]), .rsp_err(rspErr[0]),
        .busy(busySig[0])
    );

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) dutLat1 (
        .clk(clk), .reset(reset),
        .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_we(reqWe[1]),
        .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]),
        .rsp_valid(rspValid[1]), .rsp_rdata(rspRdata[1]), .rsp_err(rspErr[1]),
        .busy(busySig[1])
    );

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(4)) dutLat4 (
        .clk(clk), .reset(reset),
        .req_valid(reqValid[2]), .req_ready(reqReady[2]), .req_we(reqWe[2]),
        .req_addr(reqAddr[2]), .req_wdata(reqWdata[2]),
        .rsp_valid(rspValid[2]), .rsp_rdata(rspRdata[2]), .rsp_err(rspErr[2]),
        .busy(busySig[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int latOf(input int d);
        if (d == 0) return 2;
        if (d == 1) return 1;
        return 4;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after it is idle again.
    task automatic applyStimulus(input int d, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic expErr,
                                 input logic [31:0] expRdata, input string tag);
        int lat;
        lat = latOf(d);
        reqValid[d] = 1'b1;
        reqWe[d]    = we;
        reqAddr[d]  = addr;
        reqWdata[d] = wdata;
        @(negedge clk);
        reqValid[d] = 1'b0;
        reqWe[d]    = ~we;
        reqAddr[d]  = 32'hFFFF_FFFF;
        reqWdata[d] = 32'h0BAD_0BAD;
        for (int i = 1; i <= lat; i++) begin
            checkOutput({tag, "_ready_low"}, {31'd0, reqReady[d]}, 32'd0);
            checkOutput({tag, "_busy_high"}, {31'd0, busySig[d]}, 32'd1);
            checkOutput({tag, "_valid_timing"}, {31'd0, rspValid[d]}, (i == lat) ? 32'd1 : 32'd0);
            if (i == lat) begin
                checkOutput({tag, "_rdata"}, rspRdata[d], expRdata);
                checkOutput({tag, "_err"}, {31'd0, rspErr[d]}, {31'd0, expErr});
            end
            @(negedge clk);
        end
        checkOutput({tag, "_ready_back"}, {31'd0, reqReady[d]}, 32'd1);
        checkOutput({tag, "_valid_drop"}, {31'd0, rspValid[d]}, 32'd0);
        checkOutput({tag, "_rdata_clear"}, rspRdata[d], 32'd0);
        checkOutput({tag, "_err_clear"}, {31'd0, rspErr[d]}, 32'd0);
    endtask

    initial begin
        logic sawValid;
        logic [31:0] b2bData [4];
        b2bData[0] = 32'hA0A0_0001;
        b2bData[1] = 32'hB1B1_0002;
        b2bData[2] = 32'hC2C2_0003;
        b2bData[3] = 32'hD3D3_0004;
        for (int d = 0; d < 3; d++) begin
            reqValid[d] = 1'b0;
            reqWe[d]    = 1'b0;
            reqAddr[d]  = 32'd0;
            reqWdata[d] = 32'd0;
        end

        // Reset held for two cycles.
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_ready", {31'd0, reqReady[0]}, 32'd1);
        checkOutput("rst_busy", {31'd0, busySig[0]}, 32'd0);
        checkOutput("rst_valid", {31'd0, rspValid[0]}, 32'd0);
        checkOutput("rst_rdata", rspRdata[0], 32'd0);
        checkOutput("rst_err", {31'd0, rspErr[0]}, 32'd0);
        checkOutput("rst_ready_l1", {31'd0, reqReady[1]}, 32'd1);
        checkOutput("rst_ready_l4", {31'd0, reqReady[2]}, 32'd1);

        // Store then load at LATENCY=2.
        applyStimulus(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'd0, "st10");
        applyStimulus(0, 1'b0, 32'h0000_0010, 32'd0, 1'b0, 32'hDEAD_BEEF, "ld10");

        // Misaligned store must not write.
        applyStimulus(0, 1'b1, 32'h0000_0012, 32'h1234_5678, 1'b1, 32'd0, "st12_mis");
        applyStimulus(0, 1'b0, 32'h0000_0010, 32'd0, 1'b0, 32'hDEAD_BEEF, "ld10_after_mis");
        applyStimulus(0, 1'b0, 32'h0000_0013, 32'd0, 1'b1, 32'd0, "ld13_mis");

        // Upper address bits: error or wrap to 0x10.
`ifdef DMEM_RANGE_CHECK_EN
        applyStimulus(0, 1'b0, 32'h0000_0110, 32'd0, 1'b1, 32'd0, "ld110_range");
`else
        applyStimulus(0, 1'b0, 32'h0000_0110, 32'd0, 1'b0, 32'hDEAD_BEEF, "ld110_wrap");
`endif

        // Reset during a LATENCY=4 store discards it.
        applyStimulus(2, 1'b1, 32'h0000_0020, 32'h1111_2222, 1'b0, 32'd0, "st20_prior");
        reqValid[2] = 1'b1;
        reqWe[2]    = 1'b1;
        reqAddr[2]  = 32'h0000_0020;
        reqWdata[2] = 32'hCAFE_F00D;
        @(negedge clk);
        reqValid[2] = 1'b0;
        checkOutput("abort_busy_before", {31'd0, busySig[2]}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_ready", {31'd0, reqReady[2]}, 32'd1);
        checkOutput("abort_busy", {31'd0, busySig[2]}, 32'd0);
        reset = 1'b1;
        sawValid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (rspValid[2]) sawValid = 1'b1;
            @(negedge clk);
        end
        checkOutput("abort_no_valid", {31'd0, sawValid}, 32'd0);
        applyStimulus(2, 1'b0, 32'h0000_0020, 32'd0, 1'b0, 32'h1111_2222, "ld20_after_abort");

        // LATENCY=1: fill four words, then four back-to-back loads with req_valid held high.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 1'b1, 32'h0000_0040 + 32'(k * 4), b2bData[k], 1'b0, 32'd0, "l1_fill");
        end
        reqValid[1] = 1'b1;
        reqWe[1]    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            reqAddr[1] = 32'h0000_0040 + 32'(k * 4);
            checkOutput("b2b_ready_idle", {31'd0, reqReady[1]}, 32'd1);
            checkOutput("b2b_busy_low", {31'd0, busySig[1]}, 32'd0);
            checkOutput("b2b_valid_low", {31'd0, rspValid[1]}, 32'd0);
            @(negedge clk);
            reqAddr[1] = 32'h0000_0000;
            checkOutput("b2b_busy_high", {31'd0, busySig[1]}, 32'd1);
            checkOutput("b2b_valid_pulse", {31'd0, rspValid[1]}, 32'd1);
            checkOutput("b2b_rdata", rspRdata[1], b2bData[k]);
            @(negedge clk);
        end
        reqValid[1] = 1'b0;
        checkOutput("b2b_end_ready", {31'd0, reqReady[1]}, 32'd1);
        @(negedge clk);
        checkOutput("b2b_end_idle", {31'd0, busySig[1]}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
